bunch_of_reg_reader: RTL and testbench

- Read-side companion to the addressed 8-bit register bunch (q0..q2 written via addr select).
- Accepts read requests over a valid/ready handshake, snapshots the bank outputs and returns data over a valid/ready response channel.
- Supports a single-address read and a scan read that streams all registers in address order.
- Sits between the register bunch outputs and a host/debug readback path.

---
 rtl/bunch_of_reg_pkg.sv | 19 +
 rtl/bunch_of_reg_snapshot.sv | 44 ++++
 rtl/bunch_of_reg_reader.sv | 98 +++++++++
 tb/tb_bunch_of_reg_reader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bunch_of_reg_pkg.sv
// rtl/bunch_of_reg_pkg.sv - shared constants and types for the register bunch readback path
package bunch_of_reg_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 3;

  localparam logic [ADDR_W-1:0] ADDR_Q0 = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_Q1 = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_Q2 = ADDR_W'(2);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/bunch_of_reg_snapshot.sv
// rtl/bunch_of_reg_snapshot.sv - capture-enabled copy of q0..q2 with address-indexed read mux
module bunch_of_reg_snapshot
  import bunch_of_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_capture,
  input  logic [DATA_W-1:0] i_q0,
  input  logic [DATA_W-1:0] i_q1,
  input  logic [DATA_W-1:0] i_q2,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_err
);

  logic [DATA_W-1:0] r_snap_q0;
  logic [DATA_W-1:0] r_snap_q1;
  logic [DATA_W-1:0] r_snap_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_q0 <= '0;
      r_snap_q1 <= '0;
      r_snap_q2 <= '0;
    end else if (i_capture) begin
      r_snap_q0 <= i_q0;
      r_snap_q1 <= i_q1;
      r_snap_q2 <= i_q2;
    end
  end

  // Out-of-range addresses read as zero and flag the error.
  always_comb begin
    o_rd_data = '0;
    o_rd_err  = 1'b0;
    case (i_rd_addr)
      ADDR_Q0: o_rd_data = r_snap_q0;
      ADDR_Q1: o_rd_data = r_snap_q1;
      ADDR_Q2: o_rd_data = r_snap_q2;
      default: o_rd_err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/bunch_of_reg_reader.sv
// rtl/bunch_of_reg_reader.sv - request/response readback of the register bunch, single or scan
module bunch_of_reg_reader
  import bunch_of_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] q0,
  input  logic [DATA_W-1:0] q1,
  input  logic [DATA_W-1:0] q2,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_scan,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  output logic              rsp_last
);

  state_e            r_state;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;

  logic              w_req_fire;
  logic [ADDR_W-1:0] w_next_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_err;

  assign w_req_fire  = req_valid && r_req_ready && (r_state == ST_IDLE);
  assign w_next_addr = r_addr + ADDR_W'(1);

  bunch_of_reg_snapshot u_snapshot (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_capture (w_req_fire),
    .i_q0      (q0),
    .i_q1      (q1),
    .i_q2      (q2),
    .i_rd_addr (r_addr),
    .o_rd_data (w_rd_data),
    .o_rd_err  (w_rd_err)
  );

  // r_addr doubles as the scan index; it stops at LAST_ADDR so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_last      <= 1'b0;
      r_addr      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_state     <= ST_RESP;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b1;
            if (req_scan) begin
              r_addr <= '0;
              r_last <= (LAST_ADDR == '0);
            end else begin
              r_addr <= req_addr;
              r_last <= 1'b1;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            if (r_last) begin
              r_state     <= ST_IDLE;
              r_req_ready <= 1'b1;
              r_rsp_valid <= 1'b0;
              r_last      <= 1'b0;
            end else begin
              r_addr <= w_next_addr;
              r_last <= (w_next_addr == LAST_ADDR);
            end
          end
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_addr  = r_addr;
  assign rsp_last  = r_last;
  assign rsp_data  = r_rsp_valid ? w_rd_data : '0;
  assign rsp_err   = r_rsp_valid & w_rd_err;

endmodule

// File: tb/tb_bunch_of_reg_reader.sv
// tb/tb_bunch_of_reg_reader.sv - directed self-checking bench for bunch_of_reg_reader
module tb_bunch_of_reg_reader;

  logic       clk;
  logic       rst_n;
  logic [7:0] q0, q1, q2;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic       req_scan;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_addr;
  logic       rsp_err;
  logic       rsp_last;

  int         n_total;
  int         n_bad;
  logic [7:0] exp_d [3];

  bunch_of_reg_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_scan  (req_scan),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .rsp_last  (rsp_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, req_ready}, 32'd1);
  endtask

  // Issues a scan with the given rsp_ready pattern (LSB first, then all ones)
  // and checks every beat against exp_d while stalled and when taken.
  task automatic run_scan(input string tag, input logic [7:0] rdy_pat, input int pat_len,
                          input logic ff_after_accept);
    int k;
    int c;
    wait_ready({tag, "_ready"});
    req_valid = 1'b1;
    req_scan  = 1'b1;
    req_addr  = 2'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_scan  = 1'b0;
    if (ff_after_accept) begin
      q0 = 8'hFF;
      q1 = 8'hFF;
      q2 = 8'hFF;
    end
    k = 0;
    c = 0;
    while (k < 3 && c < 30) begin
      rsp_ready = (c < pat_len) ? rdy_pat[c] : 1'b1;
      chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_data"},  {24'd0, rsp_data},  {24'd0, exp_d[k]});
      chk({tag, "_addr"},  {30'd0, rsp_addr},  k);
      chk({tag, "_last"},  {31'd0, rsp_last},  (k == 2) ? 32'd1 : 32'd0);
      chk({tag, "_err"},   {31'd0, rsp_err},   32'd0);
      if (rsp_ready) k++;
      @(posedge clk);
      @(negedge clk);
      c++;
    end
    chk({tag, "_beats"}, k, 3);
    chk({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
    rsp_ready = 1'b1;
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    q0        = 8'h00;
    q1        = 8'h00;
    q2        = 8'h00;
    req_valid = 1'b0;
    req_addr  = 2'd0;
    req_scan  = 1'b0;
    rsp_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data",  {24'd0, rsp_data},  32'd0);
    chk("rst_rsp_addr",  {30'd0, rsp_addr},  32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    chk("rst_rsp_last",  {31'd0, rsp_last},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // Single read addr 1
    q0 = 8'h5A;
    q1 = 8'hA5;
    q2 = 8'h3C;
    req_valid = 1'b1;
    req_addr  = 2'd1;
    req_scan  = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("s1_valid",     {31'd0, rsp_valid}, 32'd1);
    chk("s1_data",      {24'd0, rsp_data},  32'hA5);
    chk("s1_addr",      {30'd0, rsp_addr},  32'd1);
    chk("s1_last",      {31'd0, rsp_last},  32'd1);
    chk("s1_err",       {31'd0, rsp_err},   32'd0);
    chk("s1_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("s1_end_valid", {31'd0, rsp_valid}, 32'd0);
    chk("s1_end_ready", {31'd0, req_ready}, 32'd1);

    // Scan, no backpressure
    q0 = 8'h11;
    q1 = 8'h22;
    q2 = 8'h33;
    exp_d[0] = 8'h11;
    exp_d[1] = 8'h22;
    exp_d[2] = 8'h33;
    run_scan("scan_fast", 8'h00, 0, 1'b0);

    // Scan, rsp_ready pattern 0,1,0,0,1,1
    run_scan("scan_stall", 8'b0011_0010, 6, 1'b0);

    // Single read out of range
    wait_ready("s3_wait");
    req_valid = 1'b1;
    req_addr  = 2'd3;
    req_scan  = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("s3_valid", {31'd0, rsp_valid}, 32'd1);
    chk("s3_data",  {24'd0, rsp_data},  32'h00);
    chk("s3_addr",  {30'd0, rsp_addr},  32'd3);
    chk("s3_err",   {31'd0, rsp_err},   32'd1);
    chk("s3_last",  {31'd0, rsp_last},  32'd1);
    @(negedge clk);
    chk("s3_hold_valid", {31'd0, rsp_valid}, 32'd1);
    chk("s3_hold_err",   {31'd0, rsp_err},   32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("s3_end_valid", {31'd0, rsp_valid}, 32'd0);

    // Snapshot coherence: bank goes to FF right after acceptance
    q0 = 8'h11;
    q1 = 8'h22;
    q2 = 8'h33;
    run_scan("scan_snap", 8'b0001_1100, 5, 1'b1);

    // Reset mid-scan after the first beat
    wait_ready("rst_scan_wait");
    q0 = 8'h44;
    q1 = 8'h55;
    q2 = 8'h66;
    req_valid = 1'b1;
    req_scan  = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_scan  = 1'b0;
    chk("mid_beat0_data", {24'd0, rsp_data}, 32'h44);
    @(negedge clk);
    chk("mid_beat1_addr", {30'd0, rsp_addr}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_addr",  {30'd0, rsp_addr},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_no_beat", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
